spi_shift_engine: RTL and testbench

Master-mode SPI serializer/deserializer sitting directly downstream of the SPI data path's transmit FIFO and upstream of its receive FIFO. It pops one standardized word from the TX FIFO, shifts out `datalen+1` bits on MOSI under a programmable SCLK with selectable CPOL/CPHA, and samples MISO into a word. It then pushes that word into the RX FIFO. Bit ordering (LSB/MSB-first) is handled upstream and downstream; this block always transmits frame bit `datalen` first.

---
 rtl/spi_shift_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// spi_shift_engine
// Master-mode SPI serializer/deserializer between the TX FIFO and the RX FIFO.
// Each frame pops one word, shifts out bits datalen..0 on mosi under a
// programmable sclk (CPOL/CPHA selectable), samples miso into a word, and
// pushes that word to the RX FIFO.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   enable              permits new frames to start
//   cpol, cpha          SPI mode, latched per frame
//   datalen             frame length minus one, latched per frame
//   clk_div             sclk half-period minus one (in clk cycles), latched per frame
//   tfifo_empty         TX FIFO empty
//   transfer_data       TX FIFO head word (show-ahead)
//   tfifo_ren           one-cycle pop strobe
//   rfifo_full          RX FIFO full
//   rfifo_wen           one-cycle push strobe
//   receive_data        last received word, masked to the frame length
//   sclk, mosi, ss_n    SPI master outputs
//   miso                SPI data in (already synchronized)
//   busy                high whenever a frame is in progress
//   rx_overrun          sticky: a received word was dropped on a full RX FIFO
//
// State table
//   state   | meaning
//   IDLE    | ss_n high, sclk parked at cpol, waiting for enable and a TX word
//   SETUP   | ss_n low, first bit on mosi, one sclk half-period before shifting
//   SHIFT   | 2N sclk edges; drive and sample according to CPHA
//   DONE    | one cycle: publish/push the received word, optionally chain next frame
//
// All outputs are registered: decisions taken in a given state appear on the
// ports one clk later (e.g. the pop strobe is visible in the first SETUP cycle,
// the push strobe in the cycle after DONE).

module spi_shift_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 5,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [LEN_WIDTH-1:0]  datalen,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic                  tfifo_empty,
  input  logic [DATA_WIDTH-1:0] transfer_data,
  output logic                  tfifo_ren,
  input  logic                  rfifo_full,
  output logic                  rfifo_wen,
  output logic [DATA_WIDTH-1:0] receive_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ss_n,
  output logic                  busy,
  output logic                  rx_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [LEN_WIDTH:0]    edge_cnt_q, edge_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_n_q, ss_n_d;
  logic                  busy_q, busy_d;
  logic                  tfifo_ren_q, tfifo_ren_d;
  logic                  rfifo_wen_q, rfifo_wen_d;
  logic [DATA_WIDTH-1:0] receive_data_q, receive_data_d;
  logic                  rx_overrun_q, rx_overrun_d;

  logic                  start;
  logic                  load;
  logic                  div_tc;
  logic                  leading;
  logic                  last_edge;
  logic [DATA_WIDTH-1:0] tx_shl;
  logic [DATA_WIDTH-1:0] rx_mask;

  assign start     = enable && !tfifo_empty;
  assign div_tc    = (div_cnt_q == '0);
  assign leading   = !edge_cnt_q[0];
  assign last_edge = (edge_cnt_q == {len_q, 1'b1});
  assign tx_shl    = tx_q << 1;
  // Two-step shift so that a 32-bit frame yields an all-ones mask.
  assign rx_mask   = ~(({DATA_WIDTH{1'b1}} << len_q) << 1);

  always_comb begin
    state_d        = state_q;
    cpol_d         = cpol_q;
    cpha_d         = cpha_q;
    len_d          = len_q;
    div_d          = div_q;
    div_cnt_d      = div_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    sclk_d         = sclk_q;
    mosi_d         = mosi_q;
    tfifo_ren_d    = 1'b0;
    rfifo_wen_d    = 1'b0;
    receive_data_d = receive_data_q;
    rx_overrun_d   = rx_overrun_q;
    load           = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        load   = start;
      end

      S_SETUP: begin
        sclk_d = cpol_q;
        if (div_tc) begin
          div_cnt_d  = div_q;
          edge_cnt_d = '0;
          state_d    = S_SHIFT;
        end else begin
          div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
      end

      S_SHIFT: begin
        if (div_tc) begin
          div_cnt_d  = div_q;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + (LEN_WIDTH+1)'(1);
          if (cpha_q != leading) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], miso};
          end
          if (cpha_q && leading) begin
            mosi_d = tx_q[len_q];
            tx_d   = tx_shl;
          end
          // After the final trailing edge there is no next bit to present.
          if (!cpha_q && !leading && !last_edge) begin
            mosi_d = tx_shl[len_q];
            tx_d   = tx_shl;
          end
          if (last_edge) begin
            state_d = S_DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
      end

      S_DONE: begin
        sclk_d         = cpol;
        receive_data_d = rx_q & rx_mask;
        rfifo_wen_d    = !rfifo_full;
        load           = start;
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      tfifo_ren_d = 1'b1;
      tx_d        = transfer_data;
      mosi_d      = transfer_data[datalen];
      rx_d        = '0;
      cpol_d      = cpol;
      cpha_d      = cpha;
      len_d       = datalen;
      div_d       = clk_div;
      div_cnt_d   = clk_div;
      edge_cnt_d  = '0;
      sclk_d      = cpol;
      state_d     = S_SETUP;
    end

    // A drop in the DONE cycle wins over a simultaneous clear so it is never lost.
    if (state_q == S_DONE && rfifo_full) begin
      rx_overrun_d = 1'b1;
    end else if (!enable) begin
      rx_overrun_d = 1'b0;
    end

    ss_n_d = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cpol_q         <= 1'b0;
      cpha_q         <= 1'b0;
      len_q          <= '0;
      div_q          <= '0;
      div_cnt_q      <= '0;
      edge_cnt_q     <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      ss_n_q         <= 1'b1;
      busy_q         <= 1'b0;
      tfifo_ren_q    <= 1'b0;
      rfifo_wen_q    <= 1'b0;
      receive_data_q <= '0;
      rx_overrun_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cpol_q         <= cpol_d;
      cpha_q         <= cpha_d;
      len_q          <= len_d;
      div_q          <= div_d;
      div_cnt_q      <= div_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      sclk_q         <= sclk_d;
      mosi_q         <= mosi_d;
      ss_n_q         <= ss_n_d;
      busy_q         <= busy_d;
      tfifo_ren_q    <= tfifo_ren_d;
      rfifo_wen_q    <= rfifo_wen_d;
      receive_data_q <= receive_data_d;
      rx_overrun_q   <= rx_overrun_d;
    end
  end

  assign tfifo_ren    = tfifo_ren_q;
  assign rfifo_wen    = rfifo_wen_q;
  assign receive_data = receive_data_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign ss_n         = ss_n_q;
  assign busy         = busy_q;
  assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Testbench for spi_shift_engine: TX/RX FIFO models, an SPI bus monitor that
// decodes mosi at the sampling edges seen on sclk, and a slave that presents
// a word on miso one bit per sampling edge.

module tb_spi_shift_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [4:0]  datalen = 5'd0;
  logic [7:0]  clk_div = 8'd0;
  logic        tfifo_empty = 1'b1;
  logic [31:0] transfer_data = 32'h0;
  logic        tfifo_ren;
  logic        rfifo_full = 1'b0;
  logic        rfifo_wen;
  logic [31:0] receive_data;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ss_n;
  logic        busy;
  logic        rx_overrun;

  spi_shift_engine #(.DATA_WIDTH(32), .LEN_WIDTH(5), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cpol(cpol), .cpha(cpha),
    .datalen(datalen), .clk_div(clk_div), .tfifo_empty(tfifo_empty),
    .transfer_data(transfer_data), .tfifo_ren(tfifo_ren), .rfifo_full(rfifo_full),
    .rfifo_wen(rfifo_wen), .receive_data(receive_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n), .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference-side state
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          mbits[$];
  int          toggles_f = 0;
  int          last_tog = 0;
  int          ren_count = 0, wen_count = 0;
  int          ren_cyc = 0, ren_cyc_prev = 0, wen_cyc = 0;
  bit          both_seen = 0;
  bit          ren_prev = 0, wen_prev = 0;
  bit          exp_cpol = 0, exp_cpha = 0;
  int          exp_h = 1;
  bit          loop_mode = 1;
  logic        miso_slave = 1'b0;
  logic [31:0] slave_word = 32'h0;
  int          sidx = 0;
  logic        sclk_prev = 1'b0;

  assign miso = loop_mode ? mosi : miso_slave;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp_v);
    end
  endtask

  function automatic void refresh_tx();
    tfifo_empty   = (txq.size() == 0);
    transfer_data = (txq.size() > 0) ? txq[0] : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Bus monitor and FIFO models
  always @(negedge clk) begin
    if (!rst_n) begin
      ren_prev  = 0;
      wen_prev  = 0;
      toggles_f = 0;
    end else begin
      if (tfifo_ren) begin
        chk("ren_one_cycle", 32'(ren_prev), 32'd0);
        chk("pop_not_empty", 32'(tfifo_empty), 32'd0);
        if (txq.size() > 0) void'(txq.pop_front());
        refresh_tx();
        ren_count++;
        ren_cyc_prev = ren_cyc;
        ren_cyc      = cyc;
        toggles_f    = 0;
        if (rfifo_wen) both_seen = 1;
      end
      if (rfifo_wen) begin
        chk("wen_one_cycle", 32'(wen_prev), 32'd0);
        chk("push_not_full", 32'(rfifo_full), 32'd0);
        rxq.push_back(receive_data);
        wen_count++;
        wen_cyc = cyc;
      end
      if (busy && (sclk !== sclk_prev)) begin
        if (toggles_f > 0) chk("half_period", 32'(cyc - last_tog), 32'(exp_h));
        last_tog = cyc;
        toggles_f++;
        // leading edge = moving away from the idle level; CPHA picks which edge samples
        if ((sclk != exp_cpol) == !exp_cpha) begin
          mbits.push_back(mosi);
          sidx--;
          if (sidx >= 0) miso_slave = slave_word[sidx];
        end
      end
      ren_prev = tfifo_ren;
      wen_prev = rfifo_wen;
    end
    sclk_prev = sclk;
  end

  task automatic run_frame(input string tag, input logic [31:0] word, input int len,
                           input int div, input bit pol, input bit pha, input bit loop,
                           input logic [31:0] sword);
    int n, h, w0, r0;
    logic [31:0] mask, got_m, exp_rx;
    n = len + 1;
    h = div + 1;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    exp_rx = (loop ? word : sword) & mask;
    cpol = pol; cpha = pha; datalen = 5'(len); clk_div = 8'(div);
    exp_cpol = pol; exp_cpha = pha; exp_h = h; loop_mode = loop;
    slave_word = sword; sidx = len; miso_slave = sword[len];
    mbits.delete(); rxq.delete();
    w0 = wen_count; r0 = ren_count;
    step();
    txq.push_back(word);
    refresh_tx();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (wen_count > w0 && !busy) break;
    end
    chk({tag, "_push_count"}, 32'(wen_count - w0), 32'd1);
    chk({tag, "_pop_count"}, 32'(ren_count - r0), 32'd1);
    chk({tag, "_rx_word"}, (rxq.size() > 0) ? rxq[0] : 32'hxxxx_xxxx, exp_rx);
    got_m = 32'h0;
    foreach (mbits[k]) got_m = (got_m << 1) | 32'(mbits[k]);
    chk({tag, "_mosi_bits"}, 32'(mbits.size()), 32'(n));
    chk({tag, "_mosi_seq"}, got_m, word & mask);
    chk({tag, "_sclk_toggles"}, 32'(toggles_f), 32'(2 * n));
    chk({tag, "_latency"}, 32'(wen_cyc - ren_cyc), 32'(h * (2 * n + 1) + 1));
    chk({tag, "_sclk_idle"}, 32'(sclk), 32'(pol));
    chk({tag, "_ss_n_idle"}, 32'(ss_n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, ss_gap;
    refresh_tx();

    // Reset values
    step(); step(); step();
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ren", 32'(tfifo_ren), 32'd0);
    chk("rst_wen", 32'(rfifo_wen), 32'd0);
    chk("rst_rdata", receive_data, 32'd0);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    cpol = 1'b1;
    rst_n = 1'b1;
    step();
    chk("sclk_settle", 32'(sclk), 32'd1);

    // 8-bit loopback, mode 0, fastest sclk
    run_frame("a5", 32'hA5, 7, 0, 0, 0, 1, 32'h0);
    chk("a5_mosi_pattern", (mbits.size() == 8) ? {24'h0, mbits[0], mbits[1], mbits[2], mbits[3],
        mbits[4], mbits[5], mbits[6], mbits[7]} : 32'hFFFF_FFFF, 32'hA5);

    // All four modes, 32-bit loopback
    for (int m = 0; m < 4; m++) begin
      run_frame($sformatf("mode%0d", m), 32'hDEAD_BEEF, 31, 3, m[1], m[0], 1, 32'h0);
    end

    // Back-to-back frames with miso held high
    enable = 1'b0;
    cpol = 0; cpha = 0; datalen = 5'd1; clk_div = 8'd0;
    exp_cpol = 0; exp_cpha = 0; exp_h = 1;
    loop_mode = 0; slave_word = 32'hFFFF_FFFF; sidx = 1; miso_slave = 1'b1;
    rxq.delete(); both_seen = 0; ss_gap = 0;
    w0 = wen_count; r0 = ren_count;
    step();
    txq.push_back(32'h3); txq.push_back(32'h1); refresh_tx();
    enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (wen_count - w0 >= 2 && !busy) break;
      if (ren_count > r0 && wen_count - w0 < 2 && ss_n && !rfifo_wen) ss_gap++;
    end
    chk("b2b_push_count", 32'(wen_count - w0), 32'd2);
    chk("b2b_pop_count", 32'(ren_count - r0), 32'd2);
    chk("b2b_ss_gap", 32'(ss_gap), 32'd0);
    chk("b2b_ren_wen_together", 32'(both_seen), 32'd1);
    chk("b2b_rx0", (rxq.size() > 0) ? rxq[0] : 32'hxxxx_xxxx, 32'h3);
    chk("b2b_rx1", (rxq.size() > 1) ? rxq[1] : 32'hxxxx_xxxx, 32'h3);
    chk("b2b_period", 32'(ren_cyc - ren_cyc_prev), 32'd6);
    enable = 1'b0;
    step();

    // RX FIFO full: dropped word sets the sticky overrun flag
    cpol = 0; cpha = 0; datalen = 5'd7; clk_div = 8'd1;
    exp_cpol = 0; exp_cpha = 0; exp_h = 2; loop_mode = 1;
    rfifo_full = 1'b1;
    w0 = wen_count; r0 = ren_count;
    txq.push_back(32'h3C); refresh_tx();
    enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (ren_count > r0 && !busy) break;
    end
    chk("ovr_no_push", 32'(wen_count - w0), 32'd0);
    chk("ovr_set", 32'(rx_overrun), 32'd1);
    repeat (5) step();
    chk("ovr_sticky", 32'(rx_overrun), 32'd1);
    enable = 1'b0;
    step();
    chk("ovr_clear", 32'(rx_overrun), 32'd0);
    rfifo_full = 1'b0;

    // Reset in the middle of a 16-bit frame
    cpol = 0; cpha = 1; datalen = 5'd15; clk_div = 8'd1;
    exp_cpol = 0; exp_cpha = 1; exp_h = 2; loop_mode = 1;
    w0 = wen_count; r0 = ren_count;
    txq.push_back(32'h1234); refresh_tx();
    enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (ren_count > r0 && toggles_f >= 5) break;
    end
    chk("mid_reached_tick5", 32'(toggles_f >= 5), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_ss_n", 32'(ss_n), 32'd1);
    chk("mid_rst_mosi", 32'(mosi), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ren", 32'(tfifo_ren), 32'd0);
    chk("mid_rst_wen", 32'(rfifo_wen), 32'd0);
    chk("mid_rst_rdata", receive_data, 32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (100) step();
    chk("mid_no_push", 32'(wen_count - w0), 32'd0);
    chk("mid_one_pop", 32'(ren_count - r0), 32'd1);
    chk("mid_idle_busy", 32'(busy), 32'd0);
    run_frame("post_rst", 32'h0000_C0DE, 15, 1, 0, 1, 1, 32'h0);

    // Enable dropped mid-frame with a second word queued
    enable = 1'b0;
    cpol = 1; cpha = 0; datalen = 5'd7; clk_div = 8'd0;
    exp_cpol = 1; exp_cpha = 0; exp_h = 1; loop_mode = 1;
    rxq.delete();
    w0 = wen_count; r0 = ren_count;
    step();
    txq.push_back(32'h5A); txq.push_back(32'hC3); refresh_tx();
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ren_count > r0) break;
    end
    repeat (4) step();
    enable = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (!busy) break;
    end
    repeat (3) step();
    chk("drop_push_count", 32'(wen_count - w0), 32'd1);
    chk("drop_pop_count", 32'(ren_count - r0), 32'd1);
    chk("drop_rx_word", (rxq.size() > 0) ? rxq[0] : 32'hxxxx_xxxx, 32'h5A);
    chk("drop_ss_n", 32'(ss_n), 32'd1);
    chk("drop_txq_left", 32'(txq.size()), 32'd1);
    txq.delete(); refresh_tx();

    // Random frames against an independent SPI slave
    for (int t = 0; t < 8; t++) begin
      int rl, rd;
      bit rp, rh;
      logic [31:0] rw, rs;
      rl = int'($urandom_range(0, 31));
      rd = int'($urandom_range(0, 3));
      rp = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      rw = $urandom;
      rs = $urandom;
      run_frame($sformatf("rnd%0d", t), rw, rl, rd, rp, rh, 0, rs);
    end

    enable = 1'b0;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
